lod_log_encoder_pipe: RTL

//  Parametrised, pipelined leading-one detector / Mitchell log encoder for the log multiplier.
//  Per operand: one-hot leading-one vector, binary position, normalised fraction, zero flag.
//  {out_pos, out_frac} is the fixed-point log2 approximation consumed by the log-domain adder.

---
 rtl/lod_log_encoder_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lod_log_encoder_pipe.sv
// lod_log_encoder_pipe
//   Two-stage pipelined leading-one detector / Mitchell log2 encoder.
//   Stage 1 captures the operand together with its leading-one position,
//   one-hot vector and zero flag. Stage 2 normalises the operand so the
//   leading one sits at the MSB and emits the MSB-aligned fraction below it.
//   {out_pos, out_frac} is the fixed-point log2 approximation.
//   Valid/ready on both sides. in_ready depends combinationally on out_ready,
//   so the pipe sustains one operand per cycle without a skid buffer.
//
//   Optional feature, controlled by macro LOD_ROUND_EN:
//     defined   - fraction rounded half-up on the first dropped bit (guard),
//                 saturating at all ones instead of carrying into pos.
//     undefined - fraction truncated.
module lod_log_encoder_pipe #(
  parameter int  WIDTH  = 16,
  parameter int  FRAC_W = 8,
  localparam int POS_W  = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_onehot,
  output logic [POS_W-1:0]  out_pos,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_zero
);

  // Pipeline state
  logic              s1_valid_q, s2_valid_q;
  // The leading one itself is implied by the position, so only the bits
  // below the operand MSB need to travel to stage 2.
  logic [WIDTH-2:0]  s1_data_q;
  logic [WIDTH-1:0]  s1_onehot_q, s2_onehot_q;
  logic [POS_W-1:0]  s1_pos_q, s2_pos_q;
  logic              s1_zero_q, s2_zero_q;
  logic [FRAC_W-1:0] s2_frac_q;

  // Next-state values
  logic [WIDTH-1:0]  s1_onehot_d;
  logic [POS_W-1:0]  s1_pos_d;
  logic              s1_zero_d;
  logic [FRAC_W-1:0] s2_frac_d;

  logic              s1_en, s2_en;
  logic [POS_W-1:0]  shamt;
  logic [WIDTH-2:0]  norm;
  logic [FRAC_W-1:0] frac_trunc;
  logic              unused_norm;

  // Stage enables: a stage advances when its successor can take its content
  // or when it is empty.
  assign s2_en    = out_ready || !s2_valid_q;
  assign s1_en    = s2_en || !s1_valid_q;
  assign in_ready = s1_en;

  // Leading-one detect on the incoming operand (highest set bit wins)
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no
    // path leaves it unassigned and no latch is inferred.
    s1_pos_d  = '0;
    s1_zero_d = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) begin
        s1_pos_d  = POS_W'(i);
        s1_zero_d = 1'b0;
      end
    end
    s1_onehot_d = s1_zero_d ? '0 : (WIDTH'(1) << s1_pos_d);
  end

  // Normalise: shift so the leading one lands just above norm's MSB, then
  // take the top FRAC_W bits. Shifting in zeros pads short fractions.
  always_comb begin
    shamt      = POS_W'(WIDTH - 1) - s1_pos_q;
    norm       = s1_data_q << shamt;
    frac_trunc = norm[WIDTH-2 -: FRAC_W];
  end

  // Bits below the fraction only matter for rounding.
  assign unused_norm = ^norm;

`ifdef LOD_ROUND_EN
  logic guard;
  if (FRAC_W <= WIDTH - 2) begin : g_guard
    assign guard = norm[WIDTH-2-FRAC_W];
  end else begin : g_no_guard
    assign guard = 1'b0;
  end
  // Round half-up; an all-ones fraction saturates instead of overflowing.
  assign s2_frac_d = (guard && !(&frac_trunc)) ? frac_trunc + FRAC_W'(1) : frac_trunc;
`else
  assign s2_frac_d = frac_trunc;
`endif

  // Stage 1: capture operand and leading-one results on accept
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of block evaluation order.
    if (rst) begin
      // NOTE: data registers are reset too (not just valids) so every output
      // reads zero during and right after reset.
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_onehot_q <= '0;
      s1_pos_q    <= '0;
      s1_zero_q   <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      // Data only loads on a real transfer, so idle in_data never enters.
      if (in_valid) begin
        s1_data_q   <= in_data[WIDTH-2:0];
        s1_onehot_q <= s1_onehot_d;
        s1_pos_q    <= s1_pos_d;
        s1_zero_q   <= s1_zero_d;
      end
    end
  end

  // Stage 2: register the final result; frozen while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_onehot_q <= '0;
      s2_pos_q    <= '0;
      s2_frac_q   <= '0;
      s2_zero_q   <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_onehot_q <= s1_onehot_q;
        s2_pos_q    <= s1_pos_q;
        s2_frac_q   <= s2_frac_d;
        s2_zero_q   <= s1_zero_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_onehot = s2_onehot_q;
  assign out_pos    = s2_pos_q;
  assign out_frac   = s2_frac_q;
  assign out_zero   = s2_zero_q;

endmodule
